note_judge_scorer: RTL and testbench



---
 rtl/note_judge_scorer.sv | 159 +++++++++++++++
 tb/tb_note_judge_scorer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge_scorer.sv
// Per-player note judge: times a hit window per row, scores hits and misses, raises game_over.
// Optional macro PERFECT_TIMING_EN: first-half-window hits earn a HIT_POINTS/2 bonus and pulse perfect_pulse.
module note_judge_scorer #(
    parameter int unsigned  NUM_ROWS      = 100,
    parameter int unsigned  WINDOW_CYCLES = 12500000,
    parameter logic [15:0]  HIT_POINTS    = 16'd10,
    parameter logic [7:0]   COMBO_THRESH  = 8'd10,
    parameter logic [7:0]   MAX_MISSES    = 8'd5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic        row_tick,
    input  logic [15:0] keycode,
    input  logic        correct_key1,
    output logic [6:0]  row_counter,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  misses,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        perfect_pulse,
    output logic        game_over
);

    localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES);
    localparam logic [6:0] LAST_ROW = 7'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, WINDOW, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] win_cnt, win_nx;
    logic [15:0]      prev_keycode;
    logic [6:0]       row_nx;
    logic [15:0]      score_nx;
    logic [7:0]       combo_nx, misses_nx;
    logic             hit_nx, miss_nx;
    logic             key_event, judge, is_hit;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a, input logic [7:0] limit);
        return (a >= limit) ? limit : a + 8'd1;
    endfunction

    // 16'h0520 is the idle/rollover pattern of the two-key report, never a press
    assign key_event = (keycode != prev_keycode) && (keycode != 16'h0000) && (keycode != 16'h0520);
    assign judge     = (state == WINDOW) && (key_event || row_tick || (win_cnt == CNT_W'(1)));
    assign is_hit    = key_event && correct_key1;
    assign game_over = (state == DONE);

`ifdef PERFECT_TIMING_EN
    localparam logic [CNT_W-1:0] WIN_HALF = CNT_W'(WINDOW_CYCLES / 2);
    logic perf_nx;
`endif

    always_comb begin
        state_nx  = state;
        win_nx    = win_cnt;
        row_nx    = row_counter;
        score_nx  = score;
        combo_nx  = combo;
        misses_nx = misses;
        hit_nx    = 1'b0;
        miss_nx   = 1'b0;
`ifdef PERFECT_TIMING_EN
        perf_nx   = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    row_nx    = '0;
                    score_nx  = '0;
                    combo_nx  = '0;
                    misses_nx = '0;
                    state_nx  = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (row_tick) begin
                    win_nx   = WIN_LOAD;
                    state_nx = WINDOW;
                end
            end
            WINDOW: begin
                win_nx = win_cnt - CNT_W'(1);
                if (judge) begin
                    if (is_hit) begin
                        score_nx = sat_add16(score, HIT_POINTS);
                        if (combo >= COMBO_THRESH)
                            score_nx = sat_add16(score_nx, HIT_POINTS);
`ifdef PERFECT_TIMING_EN
                        if (win_cnt > WIN_HALF) begin
                            score_nx = sat_add16(score_nx, HIT_POINTS >> 1);
                            perf_nx  = 1'b1;
                        end
`endif
                        combo_nx = sat_inc8(combo, 8'hFF);
                        hit_nx   = 1'b1;
                    end else begin
                        combo_nx  = '0;
                        misses_nx = sat_inc8(misses, MAX_MISSES);
                        miss_nx   = 1'b1;
                    end
                    // Hold at the last row so the key-match stage never indexes past the pattern
                    row_nx = (row_counter == LAST_ROW) ? row_counter : row_counter + 7'd1;
                    if ((row_counter == LAST_ROW) || (misses_nx >= MAX_MISSES)) begin
                        state_nx = DONE;
                    end else if (row_tick) begin
                        win_nx   = WIN_LOAD;
                        state_nx = WINDOW;
                    end else begin
                        state_nx = WAIT_ROW;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            win_cnt      <= '0;
            prev_keycode <= '0;
            row_counter  <= '0;
            score        <= '0;
            combo        <= '0;
            misses       <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
        end else begin
            state        <= state_nx;
            win_cnt      <= win_nx;
            prev_keycode <= keycode;
            row_counter  <= row_nx;
            score        <= score_nx;
            combo        <= combo_nx;
            misses       <= misses_nx;
            hit_pulse    <= hit_nx;
            miss_pulse   <= miss_nx;
        end
    end

`ifdef PERFECT_TIMING_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) perfect_pulse <= 1'b0;
        else          perfect_pulse <= perf_nx;
    end
`else
    assign perfect_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_note_judge_scorer.sv
// Bench for note_judge_scorer: table of row judgements feeding a scoreboard, plus hand-written corner sequences.
module tb_note_judge_scorer;

    localparam int WIN = 20;
`ifdef PERFECT_TIMING_EN
    localparam int FIRST_DELAY = 11;
`else
    localparam int FIRST_DELAY = 3;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        row_tick = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        correct_key1 = 1'b0;
    logic [6:0]  row_counter;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  misses;
    logic        hit_pulse, miss_pulse, perfect_pulse, game_over;

    note_judge_scorer #(
        .NUM_ROWS(100), .WINDOW_CYCLES(WIN), .HIT_POINTS(16'd10),
        .COMBO_THRESH(8'd10), .MAX_MISSES(8'd5)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .row_tick(row_tick),
        .keycode(keycode), .correct_key1(correct_key1), .row_counter(row_counter),
        .score(score), .combo(combo), .misses(misses), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .perfect_pulse(perfect_pulse), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        hit;
        logic        miss;
        logic        perf;
        logic        over;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  misses;
        logic [6:0]  row;
    } exp_t;

    typedef struct {
        int          kind;   // 0 hit, 1 wrong key, 2 timeout, 3 timeout with 16'h0520 on the bus
        int          delay;
        logic [15:0] key;
        exp_t        e;
    } row_t;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    row_t tbl[18];

    function automatic exp_t mk(input logic h, input logic m, input logic p, input logic o,
                                input int sc, input int cb, input int ms, input int rw);
        exp_t e;
        e.hit = h; e.miss = m; e.perf = p; e.over = o;
        e.score = 16'(sc); e.combo = 8'(cb); e.misses = 8'(ms); e.row = 7'(rw);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (hit_pulse || miss_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, hit_pulse, miss_pulse}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("hit_pulse", hit_pulse, mon_e.hit);
                chk("miss_pulse", miss_pulse, mon_e.miss);
                chk("perfect_pulse", perfect_pulse, mon_e.perf);
                chk("game_over", game_over, mon_e.over);
                chk("score", score, mon_e.score);
                chk("combo", combo, mon_e.combo);
                chk("misses", misses, mon_e.misses);
                chk("row_counter", row_counter, mon_e.row);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_row(input int kind, input int delay, input logic [15:0] key,
                          input bit hold, input exp_t e);
        int n;
        sb.push_back(e);
        if (!hold) keycode = 16'h0000;
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        if (kind >= 2) begin
            n = 0;
            for (int i = 1; i <= 30; i++) begin
                step();
                if (kind == 3 && i == 3) begin
                    keycode = 16'h0520;
                    correct_key1 = 1'b1;
                end
                if (miss_pulse) begin
                    n = i;
                    break;
                end
            end
            correct_key1 = 1'b0;
            chk("timeout_latency", n, WIN);
        end else begin
            repeat (delay) step();
            keycode = key;
            correct_key1 = (kind == 0);
            step();
            correct_key1 = 1'b0;
        end
        drain();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, FIRST_DELAY, 16'h0004, mk(1, 0, 0, 0, 10, 1, 0, 1)};
        tbl[1] = '{2, 0, 16'h0000, mk(0, 1, 0, 0, 10, 0, 1, 2)};
        for (int i = 1; i <= 12; i++)
            tbl[1+i] = '{0, 11, 16'(16'h0004 + i),
                         mk(1, 0, 0, 0, (i <= 10) ? 10 + 10*i : 110 + 20*(i-10), i, 1, 2 + i)};
        tbl[14] = '{1, 4, 16'h0015, mk(0, 1, 0, 0, 150, 0, 2, 15)};
        tbl[15] = '{1, 6, 16'h0016, mk(0, 1, 0, 0, 150, 0, 3, 16)};
        tbl[16] = '{3, 0, 16'h0000, mk(0, 1, 0, 0, 150, 0, 4, 17)};
        tbl[17] = '{1, 2, 16'h0017, mk(0, 1, 0, 1, 150, 0, 5, 18)};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_misses", misses, 0);
        chk("rst_row", row_counter, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse, perfect_pulse}, 0);
        chk("rst_game_over", game_over, 0);
        Reset_n = 1'b1;
        step();
        pulse_start();

        for (int i = 0; i < 18; i++)
            do_row(tbl[i].kind, tbl[i].delay, tbl[i].key, 1'b0, tbl[i].e);

        // DONE ignores further rows
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        repeat (25) step();
        chk("done_game_over", game_over, 1);
        chk("done_score", score, 150);
        chk("done_row", row_counter, 18);
        chk("done_misses", misses, 5);

        pulse_start();
        chk("restart_game_over", game_over, 0);
        chk("restart_score", score, 0);
        chk("restart_row", row_counter, 0);
        chk("restart_misses", misses, 0);

        // Held key: first window hits, second times out
        do_row(0, 11, 16'h0004, 1'b0, mk(1, 0, 0, 0, 10, 1, 0, 1));
        do_row(2, 0, 16'h0000, 1'b1, mk(0, 1, 0, 0, 10, 0, 1, 2));
        // Key event on the expiry cycle is a hit
        do_row(0, WIN - 1, 16'h0006, 1'b0, mk(1, 0, 0, 0, 20, 1, 1, 3));

        // row_tick mid-window: timeout miss, then straight back into a fresh window
        sb.push_back(mk(0, 1, 0, 0, 20, 0, 2, 4));
        sb.push_back(mk(1, 0, 0, 0, 30, 1, 2, 5));
        keycode = 16'h0000;
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        repeat (5) step();
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        repeat (11) step();
        keycode = 16'h0007;
        correct_key1 = 1'b1;
        step();
        correct_key1 = 1'b0;
        drain();
        chk("pre_reset_score", score, 30);

        // Asynchronous reset in the middle of a window
        keycode = 16'h0000;
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        repeat (2) step();
        Reset_n = 1'b0;
        #1;
        chk("async_rst_score", score, 0);
        chk("async_rst_combo", combo, 0);
        chk("async_rst_misses", misses, 0);
        chk("async_rst_row", row_counter, 0);
        chk("async_rst_over", game_over, 0);
        step();
        Reset_n = 1'b1;
        step();
        row_tick = 1'b1;
        step();
        row_tick = 1'b0;
        repeat (25) step();
        chk("idle_row", row_counter, 0);
        chk("idle_over", game_over, 0);

        // Early hit: bonus only with the perfect-timing build
        pulse_start();
`ifdef PERFECT_TIMING_EN
        do_row(0, 5, 16'h0008, 1'b0, mk(1, 0, 1, 0, 15, 1, 0, 1));
`else
        do_row(0, 5, 16'h0008, 1'b0, mk(1, 0, 0, 0, 10, 1, 0, 1));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
